// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side master for the team FIFO. It issues read requests and captures
//   the FIFO output into a 3-entry circular buffer. Buffered words are
//   presented on a valid/ready stream with sop/eop framing every PKT_LEN words.
//   Reads are issued on credit: outstanding plus buffered words never exceed
//   three. fifo_rdreq_o therefore never depends on ready_i, and the stream
//   sustains one word per clock.
// Ports
//   clk_i, srst_i      clock, synchronous active-high reset
//   fifo_q_i           FIFO read data
//   fifo_empty_i       FIFO empty flag
//   fifo_usedw_i       FIFO fill level (status, checked only)
//   fifo_rdreq_o       FIFO read request
//   data_o, valid_o    stream word and qualifier
//   ready_i            stream consumer ready
//   sop_o, eop_o       packet framing, qualified by valid_o
//   pkt_cnt_o          completed packets, wraps at 2^16

module fifo_stream_reader_chk #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input logic              clk_i,
  input logic              srst_i,
  input logic              fifo_rdreq_o,
  input logic              fifo_empty_i,
  input logic [AWIDTH-1:0] fifo_usedw_i,
  input logic [1:0]        occ,
  input logic              inflight,
  input logic              valid_o,
  input logic              ready_i,
  input logic [DWIDTH-1:0] data_o,
  input logic              sop_o,
  input logic              eop_o
);
  a_no_read_empty: assert property (@(posedge clk_i) !(fifo_rdreq_o && fifo_empty_i));
  a_occ_bound:     assert property (@(posedge clk_i) ({1'b0, occ} + {2'b00, inflight}) <= 3'd3);
  a_empty_usedw:   assert property (@(posedge clk_i) fifo_empty_i |-> (fifo_usedw_i == '0));
  a_stall_stable:  assert property (@(posedge clk_i) disable iff (srst_i)
                                    (valid_o && !ready_i) |=> $stable({data_o, sop_o, eop_o}));
endmodule

module fifo_stream_reader #(
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 8,
  parameter int SHOWAHEAD = 0,
  parameter int PKT_LEN   = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH-1:0] fifo_usedw_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sop_o,
  output logic              eop_o,
  output logic [15:0]       pkt_cnt_o
);
  localparam int IDXW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PKT_LEN - 1);

  logic [DWIDTH-1:0] r_mem [0:2];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [1:0]        r_occ;
  logic              r_inflight;
  logic [IDXW-1:0]   r_idx;
  logic [15:0]       r_pkt_cnt;

  logic [2:0]        w_credit;
  logic              w_rdreq;
  logic              w_push;
  logic              w_valid;
  logic              w_pop;
  logic              w_last;

  // Circular pointer over three entries.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit-based read request, buffer push/pop strobes and framing position.
  always_comb begin
    w_credit = {1'b0, r_occ} + {2'b00, r_inflight};
    w_rdreq  = !srst_i && !fifo_empty_i && (w_credit <= 3'd2);
    // Show-ahead data is already on q while rdreq acknowledges it; otherwise
    // the word arrives one clock after the request.
    if (SHOWAHEAD != 0) begin
      w_push = w_rdreq;
    end else begin
      w_push = r_inflight && !srst_i;
    end
    w_valid = (r_occ != 2'd0) && !srst_i;
    w_pop   = w_valid && ready_i;
    w_last  = (r_idx == LAST_IDX);
  end

  // Buffer bookkeeping, word index and packet counter.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_idx      <= '0;
      r_pkt_cnt  <= 16'd0;
    end else begin
      r_inflight <= (SHOWAHEAD == 0) ? w_rdreq : 1'b0;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      if (w_pop) begin
        r_idx <= w_last ? '0 : r_idx + IDXW'(1);
        if (w_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
    end
  end

  // Buffer storage; w_push is already blocked during reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= fifo_q_i;
  end

  // Outputs are forced low combinationally while srst_i is high.
  assign fifo_rdreq_o = w_rdreq;
  assign valid_o      = w_valid;
  assign data_o       = w_valid ? r_mem[r_rd_ptr] : '0;
  assign sop_o        = w_valid && (r_idx == '0);
  assign eop_o        = w_valid && w_last;
  assign pkt_cnt_o    = srst_i ? 16'd0 : r_pkt_cnt;

  fifo_stream_reader_chk #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_chk (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .fifo_rdreq_o (w_rdreq),
    .fifo_empty_i (fifo_empty_i),
    .fifo_usedw_i (fifo_usedw_i),
    .occ          (r_occ),
    .inflight     (r_inflight),
    .valid_o      (w_valid),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .sop_o        (sop_o),
    .eop_o        (eop_o)
  );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader. Three instances:
//   0: SHOWAHEAD=0, PKT_LEN=8   1: SHOWAHEAD=1, PKT_LEN=8   2: SHOWAHEAD=0, PKT_LEN=1
// Each instance reads from a behavioural FIFO held in fmem. The reference is
// the rule that the stream reproduces the FIFO contents in order: handshake n
// carries fmem[base+n], sop when n%PKT_LEN==0, eop when n%PKT_LEN==PKT_LEN-1,
// and pkt_cnt equals (n / PKT_LEN) mod 2^16.
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst = 1'b1;
  logic [15:0] fq_in [3];
  logic        f_empty [3];
  logic [7:0]  usedw [3];
  logic        rdreq [3];
  logic        valid [3];
  logic        sop [3];
  logic        eop [3];
  logic        rdy [3];
  logic [15:0] dout [3];
  logic [15:0] pkt [3];

  logic [15:0] fmem [3][65800];
  int          f_rd [3] = '{0, 0, 0};
  int          f_wr [3] = '{0, 0, 0};
  logic [15:0] f_qreg [3];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural FIFOs: instances 0/2 see q one clock after rdreq, instance 1 is show-ahead.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rdreq[k]) begin
        f_qreg[k] <= fmem[k][f_rd[k]];
        f_rd[k]   <= f_rd[k] + 1;
      end
    end
  end

  assign fq_in[0]   = f_qreg[0];
  assign fq_in[1]   = fmem[1][f_rd[1]];
  assign fq_in[2]   = f_qreg[2];
  assign f_empty[0] = (f_wr[0] == f_rd[0]);
  assign f_empty[1] = (f_wr[1] == f_rd[1]);
  assign f_empty[2] = (f_wr[2] == f_rd[2]);
  assign usedw[0]   = 8'(f_wr[0] - f_rd[0]);
  assign usedw[1]   = 8'(f_wr[1] - f_rd[1]);
  assign usedw[2]   = 8'(f_wr[2] - f_rd[2]);

  fifo_stream_reader #(.DWIDTH(16), .AWIDTH(8), .SHOWAHEAD(0), .PKT_LEN(8)) u0 (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(fq_in[0]), .fifo_empty_i(f_empty[0]),
    .fifo_usedw_i(usedw[0]), .fifo_rdreq_o(rdreq[0]), .data_o(dout[0]), .valid_o(valid[0]),
    .ready_i(rdy[0]), .sop_o(sop[0]), .eop_o(eop[0]), .pkt_cnt_o(pkt[0]));

  fifo_stream_reader #(.DWIDTH(16), .AWIDTH(8), .SHOWAHEAD(1), .PKT_LEN(8)) u1 (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(fq_in[1]), .fifo_empty_i(f_empty[1]),
    .fifo_usedw_i(usedw[1]), .fifo_rdreq_o(rdreq[1]), .data_o(dout[1]), .valid_o(valid[1]),
    .ready_i(rdy[1]), .sop_o(sop[1]), .eop_o(eop[1]), .pkt_cnt_o(pkt[1]));

  fifo_stream_reader #(.DWIDTH(16), .AWIDTH(8), .SHOWAHEAD(0), .PKT_LEN(1)) u2 (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(fq_in[2]), .fifo_empty_i(f_empty[2]),
    .fifo_usedw_i(usedw[2]), .fifo_rdreq_o(rdreq[2]), .data_o(dout[2]), .valid_o(valid[2]),
    .ready_i(rdy[2]), .sop_o(sop[2]), .eop_o(eop[2]), .pkt_cnt_o(pkt[2]));

  // Load n random words into FIFO k.
  task automatic push(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[k][f_wr[k]] = 16'($urandom);
      f_wr[k] = f_wr[k] + 1;
    end
  endtask

  // Drive srst high across one rising edge; caller releases it.
  task automatic enter_reset;
    @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    srst = 1'b1;
    rdy[0] = 1'b1;
    push(0, 1);
    #1;
    n_checks++; if (rdreq[0] !== 1'b0) begin n_errors++; $display("FAIL reset_rdreq: got %0b expected 0", rdreq[0]); end
    n_checks++; if ({valid[0], sop[0], eop[0]} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %03b expected 000", {valid[0], sop[0], eop[0]}); end
    n_checks++; if (dout[0] !== 16'h0000) begin n_errors++; $display("FAIL reset_data: got %h expected 0000", dout[0]); end
    n_checks++; if (pkt[0] !== 16'd0) begin n_errors++; $display("FAIL reset_pkt: got %0d expected 0", pkt[0]); end
    @(negedge clk);
    srst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_checks++; if (valid[0] !== (c == 2)) begin n_errors++; $display("FAIL reset_first_valid c=%0d: got %0b expected %0b", c, valid[0], (c == 2)); end
      if (c == 2) begin
        n_checks++; if ({dout[0], sop[0], eop[0]} !== {fmem[0][f_wr[0] - 1], 1'b1, 1'b0}) begin
          n_errors++; $display("FAIL reset_first_word: got %h/%0b/%0b expected %h/1/0", dout[0], sop[0], eop[0], fmem[0][f_wr[0] - 1]); end
      end
    end
  endtask

  task automatic test_stream;
    int base, hs, last_c;
    enter_reset();
    base = f_rd[0]; hs = 0; last_c = -1;
    push(0, 16);
    srst = 1'b0; rdy[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 0) begin
        n_checks++; if (rdreq[0] !== 1'b1) begin n_errors++; $display("FAIL stream_rdreq0: got %0b expected 1", rdreq[0]); end
      end
      if (c <= 2) begin
        n_checks++; if (valid[0] !== (c == 2)) begin n_errors++; $display("FAIL stream_latency c=%0d: got %0b expected %0b", c, valid[0], (c == 2)); end
      end
      if (valid[0] && rdy[0]) begin
        n_checks++; if ({dout[0], sop[0], eop[0]} !== {fmem[0][base + hs], (hs % 8 == 0), (hs % 8 == 7)}) begin
          n_errors++; $display("FAIL stream_word %0d: got %h/%0b/%0b expected %h/%0b/%0b", hs, dout[0], sop[0], eop[0], fmem[0][base + hs], (hs % 8 == 0), (hs % 8 == 7)); end
        hs++; last_c = c;
      end
    end
    n_checks++; if (hs !== 16) begin n_errors++; $display("FAIL stream_count: got %0d expected 16", hs); end
    n_checks++; if (last_c !== 17) begin n_errors++; $display("FAIL stream_last_cycle: got %0d expected 17", last_c); end
    n_checks++; if (pkt[0] !== 16'd2) begin n_errors++; $display("FAIL stream_pkt: got %0d expected 2", pkt[0]); end
  endtask

  task automatic test_backpressure;
    int base, hs, n_rd;
    enter_reset();
    base = f_rd[0]; hs = 0; n_rd = 0;
    push(0, 8);
    srst = 1'b0; rdy[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rdreq[0]) n_rd++;
      if (c >= 2) begin
        n_checks++; if ({valid[0], dout[0]} !== {1'b1, fmem[0][base]}) begin
          n_errors++; $display("FAIL bp_hold c=%0d: got %0b/%h expected 1/%h", c, valid[0], dout[0], fmem[0][base]); end
      end
    end
    n_checks++; if (n_rd !== 3) begin n_errors++; $display("FAIL bp_reads: got %0d expected 3", n_rd); end
    for (int c = 10; c < 40; c++) begin
      @(negedge clk);
      rdy[0] = 1'b1;
      #1;
      if (valid[0] && rdy[0]) begin
        n_checks++; if (dout[0] !== fmem[0][base + hs]) begin
          n_errors++; $display("FAIL bp_word %0d: got %h expected %h", hs, dout[0], fmem[0][base + hs]); end
        hs++;
      end
    end
    n_checks++; if (hs !== 8) begin n_errors++; $display("FAIL bp_count: got %0d expected 8", hs); end
    n_checks++; if (pkt[0] !== 16'd1) begin n_errors++; $display("FAIL bp_pkt: got %0d expected 1", pkt[0]); end
  endtask

  task automatic test_toggle;
    int base, hs, n_eop;
    enter_reset();
    base = f_rd[0]; hs = 0; n_eop = 0;
    push(0, 32);
    srst = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (c > 0) @(negedge clk);
      rdy[0] = (c % 2 == 0);
      #1;
      n_checks++; if (rdreq[0] && f_empty[0]) begin n_errors++; $display("FAIL toggle_rd_empty c=%0d: got rdreq=1 expected 0", c); end
      if (valid[0] && rdy[0]) begin
        n_checks++; if ({dout[0], eop[0]} !== {fmem[0][base + hs], (hs % 8 == 7)}) begin
          n_errors++; $display("FAIL toggle_word %0d: got %h/%0b expected %h/%0b", hs, dout[0], eop[0], fmem[0][base + hs], (hs % 8 == 7)); end
        if (eop[0]) n_eop++;
        hs++;
      end
    end
    n_checks++; if (hs !== 32) begin n_errors++; $display("FAIL toggle_count: got %0d expected 32", hs); end
    n_checks++; if (n_eop !== 4) begin n_errors++; $display("FAIL toggle_eops: got %0d expected 4", n_eop); end
    n_checks++; if (pkt[0] !== 16'd4) begin n_errors++; $display("FAIL toggle_pkt: got %0d expected 4", pkt[0]); end
  endtask

  task automatic test_random;
    int base, hs, total;
    logic prev_stall;
    logic [17:0] prev_out;
    enter_reset();
    base = f_rd[0]; hs = 0; total = 5; prev_stall = 1'b0; prev_out = '0;
    push(0, 5);
    srst = 1'b0;
    for (int c = 0; c < 340; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 300 && $urandom_range(0, 3) == 0) begin push(0, 1); total++; end
      rdy[0] = (c >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        n_checks++; if ({dout[0], sop[0], eop[0]} !== prev_out) begin
          n_errors++; $display("FAIL rand_stall_stable c=%0d: got %h expected %h", c, {dout[0], sop[0], eop[0]}, prev_out); end
      end
      if (valid[0] && rdy[0]) begin
        n_checks++; if ({dout[0], sop[0], eop[0]} !== {fmem[0][base + hs], (hs % 8 == 0), (hs % 8 == 7)}) begin
          n_errors++; $display("FAIL rand_word %0d: got %h/%0b/%0b expected %h/%0b/%0b", hs, dout[0], sop[0], eop[0], fmem[0][base + hs], (hs % 8 == 0), (hs % 8 == 7)); end
        hs++;
      end
      prev_stall = valid[0] && !rdy[0];
      prev_out   = {dout[0], sop[0], eop[0]};
    end
    n_checks++; if (hs !== total) begin n_errors++; $display("FAIL rand_count: got %0d expected %0d", hs, total); end
    n_checks++; if (pkt[0] !== 16'(hs / 8)) begin n_errors++; $display("FAIL rand_pkt: got %0d expected %0d", pkt[0], hs / 8); end
  endtask

  task automatic test_showahead;
    int base, hs;
    enter_reset();
    base = f_rd[1]; hs = 0;
    push(1, 5);
    srst = 1'b0; rdy[1] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 0) begin
        n_checks++; if (rdreq[1] !== 1'b1) begin n_errors++; $display("FAIL sa_rdreq0: got %0b expected 1", rdreq[1]); end
      end
      if (c <= 1) begin
        n_checks++; if (valid[1] !== (c == 1)) begin n_errors++; $display("FAIL sa_latency c=%0d: got %0b expected %0b", c, valid[1], (c == 1)); end
      end
      if (valid[1] && rdy[1]) begin
        n_checks++; if ({dout[1], sop[1], eop[1]} !== {fmem[1][base + hs], (hs == 0), 1'b0}) begin
          n_errors++; $display("FAIL sa_word %0d: got %h/%0b/%0b expected %h/%0b/0", hs, dout[1], sop[1], eop[1], fmem[1][base + hs], (hs == 0)); end
        hs++;
      end
    end
    n_checks++; if (hs !== 5) begin n_errors++; $display("FAIL sa_count: got %0d expected 5", hs); end
    n_checks++; if (pkt[1] !== 16'd0) begin n_errors++; $display("FAIL sa_pkt: got %0d expected 0", pkt[1]); end
  endtask

  task automatic test_reset_mid;
    int base, nbase, hs;
    enter_reset();
    base = f_rd[0]; hs = 0;
    push(0, 8);
    srst = 1'b0; rdy[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
    end
    n_checks++; if ({valid[0], rdreq[0]} !== 2'b11) begin n_errors++; $display("FAIL mid_pre_state: got %02b expected 11", {valid[0], rdreq[0]}); end
    @(negedge clk);
    srst = 1'b1;
    #1;
    n_checks++; if ({valid[0], rdreq[0], sop[0]} !== 3'b000) begin n_errors++; $display("FAIL mid_reset_same: got %03b expected 000", {valid[0], rdreq[0], sop[0]}); end
    nbase = f_rd[0];
    n_checks++; if (nbase - base !== 3) begin n_errors++; $display("FAIL mid_reads: got %0d expected 3", nbase - base); end
    @(negedge clk);
    srst = 1'b0;
    #1;
    n_checks++; if (valid[0] !== 1'b0) begin n_errors++; $display("FAIL mid_valid_after: got %0b expected 0", valid[0]); end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      rdy[0] = 1'b1;
      #1;
      if (valid[0] && rdy[0]) begin
        n_checks++; if ({dout[0], sop[0]} !== {fmem[0][nbase + hs], (hs == 0)}) begin
          n_errors++; $display("FAIL mid_word %0d: got %h/%0b expected %h/%0b", hs, dout[0], sop[0], fmem[0][nbase + hs], (hs == 0)); end
        hs++;
      end
    end
    n_checks++; if (hs !== 5) begin n_errors++; $display("FAIL mid_count: got %0d expected 5", hs); end
    n_checks++; if (pkt[0] !== 16'd0) begin n_errors++; $display("FAIL mid_pkt: got %0d expected 0", pkt[0]); end
  endtask

  task automatic test_pkt1_wrap;
    int base, hs, nw;
    nw = 65540;
    enter_reset();
    base = f_rd[2]; hs = 0;
    push(2, nw);
    srst = 1'b0; rdy[2] = 1'b1;
    for (int c = 0; c < nw + 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (hs == 65536) begin
        n_checks++; if (pkt[2] !== 16'd0) begin n_errors++; $display("FAIL p1_wrap_zero: got %0d expected 0", pkt[2]); end
      end
      if (valid[2] && rdy[2]) begin
        n_checks++; if ({dout[2], sop[2], eop[2]} !== {fmem[2][base + hs], 1'b1, 1'b1}) begin
          n_errors++; $display("FAIL p1_word %0d: got %h/%0b/%0b expected %h/1/1", hs, dout[2], sop[2], eop[2], fmem[2][base + hs]); end
        hs++;
      end
      if (hs == nw) break;
    end
    @(negedge clk);
    #1;
    n_checks++; if (hs !== nw) begin n_errors++; $display("FAIL p1_count: got %0d expected %0d", hs, nw); end
    n_checks++; if (pkt[2] !== 16'd4) begin n_errors++; $display("FAIL p1_pkt: got %0d expected 4", pkt[2]); end
  endtask

  initial begin
    rdy[0] = 1'b1; rdy[1] = 1'b1; rdy[2] = 1'b1;
    srst = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_random();
    test_showahead();
    test_reset_mid();
    test_pkt1_wrap();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
